// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr -- round-robin Wishbone classic arbiter, NUM_MASTERS -> 1 slave.
//
// The arbiter grants the bus to one master at a time and feeds that master's
// request onto a single shared slave bus, for example the bus into an address
// decoder. In IDLE it picks the first requesting master after the previous
// owner, searching with wrap-around. That master keeps the bus for as long as
// it holds CYC, so back-to-back transfers and read-modify-write sequences are
// never split.
//
// Handshake: this is Wishbone classic. A transfer completes in the cycle where
// cyc, stb and ack are all high. Read data (m_rdt) is broadcast to every
// master, and each master qualifies it with its own m_ack bit.
//
// Optional feature (macro WB_ARB_WDT_EN): a bus-cycle watchdog. It aborts a
// strobe that the slave leaves unacknowledged for TIMEOUT cycles. The abort
// gives the owner a one-cycle m_err and a one-cycle tmo pulse, and the FSM
// then parks in ABORT until the owner drops CYC. When the macro is not defined,
// m_err and tmo are tied low.
//
// Ports:
//   wb_clk, wb_rst_n      clock and asynchronous active-low reset
//   m_cyc/m_stb/m_we      per-master controls, one bit per master
//   m_sel/m_adr/m_dat     packed per-master SEL, ADR and write data (slice i = master i)
//   m_rdt                 read data, broadcast to all masters (always s_rdt)
//   m_ack/m_err           per-master ACK and watchdog ERR
//   s_cyc/s_stb/s_we/s_sel/s_adr/s_dat   shared slave bus, driven from the owner
//   s_rdt/s_ack           slave read data and slave ACK
//   busid                 one-hot owner; all zero when idle
//   tmo                   one-cycle pulse on a watchdog abort
module wb_arbiter_rr #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 127
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst_n,
  input  logic [NUM_MASTERS-1:0]      m_cyc,
  input  logic [NUM_MASTERS-1:0]      m_stb,
  input  logic [NUM_MASTERS-1:0]      m_we,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat,
  output logic [DW-1:0]               m_rdt,
  output logic [NUM_MASTERS-1:0]      m_ack,
  output logic [NUM_MASTERS-1:0]      m_err,
  output logic                        s_cyc,
  output logic                        s_stb,
  output logic                        s_we,
  output logic [DW/8-1:0]             s_sel,
  output logic [AW-1:0]               s_adr,
  output logic [DW-1:0]               s_dat,
  input  logic [DW-1:0]               s_rdt,
  input  logic                        s_ack,
  output logic [NUM_MASTERS-1:0]      busid,
  output logic                        tmo
);

  localparam int SW = DW / 8;
  localparam int IW = $clog2(NUM_MASTERS);

`ifdef WB_ARB_WDT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, ABORT = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_e;
`endif

  state_e                 state_q;
  logic [IW-1:0]          last_q;    // previous winner, and the current owner while busid_q != 0
  logic [IW-1:0]          last_d;
  logic [IW-1:0]          idx;
  logic [NUM_MASTERS-1:0] busid_q;
  logic [NUM_MASTERS-1:0] onehot_d;

  // Round-robin pick. The loop walks the offsets from farthest to nearest, so
  // the nearest requester after last_q is assigned last and wins.
  always_comb begin
    last_d = last_q;
    idx    = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = IW'((int'(last_q) + k) % NUM_MASTERS);
      if (m_cyc[idx]) last_d = idx;
    end
    onehot_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << last_d;
  end

  logic granted, on_bus, own_cyc, own_stb;
  assign granted = (state_q == GRANT);
  assign on_bus  = (state_q != IDLE);
  assign own_cyc = m_cyc[last_q];
  assign own_stb = m_stb[last_q];

`ifdef WB_ARB_WDT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wdt_q;
  logic          stall, expire;
  assign stall  = granted & own_cyc & own_stb & ~s_ack;
  // The abort fires in the stalled cycle that would bring the count to
  // TIMEOUT. Because a stall requires ~s_ack, an ack in that same cycle wins.
  assign expire = stall & (wdt_q == CW'(TIMEOUT - 1));
  assign tmo    = expire;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0);
  assign tmo        = 1'b0;
`endif

  // Slave bus: controls only while GRANT; payload muxed while a master is on the bus.
  assign s_cyc = granted & own_cyc;
  assign s_stb = granted & own_stb;
  assign s_we  = on_bus & m_we[last_q];
  assign s_sel = on_bus ? m_sel[int'(last_q)*SW +: SW] : '0;
  assign s_adr = on_bus ? m_adr[int'(last_q)*AW +: AW] : '0;
  assign s_dat = on_bus ? m_dat[int'(last_q)*DW +: DW] : '0;
  assign m_rdt = s_rdt;
  assign busid = busid_q;

  always_comb begin
    m_ack = '0;
    m_err = '0;
    if (granted) m_ack[last_q] = s_ack;
`ifdef WB_ARB_WDT_EN
    if (expire) m_err[last_q] = 1'b1;
`endif
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_MASTERS - 1);
      busid_q <= '0;
`ifdef WB_ARB_WDT_EN
      wdt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|m_cyc) begin
            state_q <= GRANT;
            last_q  <= last_d;
            busid_q <= onehot_d;
          end
        end
        GRANT: begin
          if (!own_cyc) begin
            state_q <= IDLE;
            busid_q <= '0;
          end
`ifdef WB_ARB_WDT_EN
          else if (expire) begin
            state_q <= ABORT;
          end
          if (!own_cyc || expire || s_ack) wdt_q <= '0;
          else if (stall)                   wdt_q <= wdt_q + 1'b1;
`endif
        end
`ifdef WB_ARB_WDT_EN
        ABORT: begin
          // busid is held until the aborted owner releases CYC.
          if (!own_cyc) begin
            state_q <= IDLE;
            busid_q <= '0;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          busid_q <= '0;
        end
      endcase
    end
  end

endmodule
